wb_port_arbiter: RTL and testbench

Round-robin arbiter sharing the single register-file write port among three writeback requesters: 0 = ALU result, 1 = load data, 2 = multicycle unit / PC+4. It accepts one request per cycle through a valid/ready handshake and captures the winner's data and destination in a one-entry output register. It drives the register-file write port from that register and exports the 2-bit source select. It sits between the execute/memory stages and the register file.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/rr_pick3.sv | 32 +++
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 tb/tb_wb_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback-port arbiter.
// Source encodings double as requester indices.
package wb_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned RW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned REG_X0 = 0;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU  = 2'd0;
  localparam src_idx_t SRC_LOAD = 2'd1;
  localparam src_idx_t SRC_AUX  = 2'd2;

  // Successor in the 0 -> 1 -> 2 -> 0 ring; the unused code 3 folds onto 0.
  function automatic src_idx_t next_src(input src_idx_t i);
    return (i >= SRC_AUX) ? SRC_ALU : src_idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: searches last+1, last+2, last and returns
// a one-hot grant plus its encoded index.
module rr_pick3
  import wb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  src_idx_t        last,
  output logic [NREQ-1:0] grant,
  output src_idx_t        idx
);

  src_idx_t first, second, third;

  always_comb begin
    first  = next_src(last);
    second = next_src(first);
    third  = next_src(second);
    grant  = '0;
    idx    = SRC_ALU;
    if (valid[first]) begin
      idx = first;
    end else if (valid[second]) begin
      idx = second;
    end else if (valid[third]) begin
      idx = third;
    end
    if (|valid) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port with a
// one-entry output register that drains straight into the port.
module wb_port_arbiter
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [DW-1:0]   req_data0,
  input  logic [DW-1:0]   req_data1,
  input  logic [DW-1:0]   req_data2,
  input  logic [RW-1:0]   req_rd0,
  input  logic [RW-1:0]   req_rd1,
  input  logic [RW-1:0]   req_rd2,
  input  logic            rf_stall,
  output logic            rf_we,
  output logic [RW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_wd,
  output logic [1:0]      sel,
  output logic            busy
);

  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_rd_q, out_rd_d;
  logic [DW-1:0]   out_wd_q, out_wd_d;
  src_idx_t        sel_q, sel_d;
  src_idx_t        last_q, last_d;

  logic [NREQ-1:0] pick_grant;
  src_idx_t        pick_idx;
  logic [DW-1:0]   mux_wd;
  logic [RW-1:0]   mux_rd;
  logic            free, xfer, retire;

  rr_pick3 u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // The slot is free when empty or when the held entry retires this cycle.
  assign free      = ~out_valid_q | ~rf_stall;
  assign req_ready = (free & rst_n) ? pick_grant : '0;
  assign xfer      = |req_ready;
  assign retire    = out_valid_q & ~rf_stall;

  always_comb begin
    mux_wd = req_data0;
    mux_rd = req_rd0;
    case (pick_idx)
      SRC_LOAD: begin
        mux_wd = req_data1;
        mux_rd = req_rd1;
      end
      SRC_AUX: begin
        mux_wd = req_data2;
        mux_rd = req_rd2;
      end
      default: begin
        mux_wd = req_data0;
        mux_rd = req_rd0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_wd_d    = out_wd_q;
    sel_d       = sel_q;
    last_d      = last_q;
    if (xfer) begin
      // Refill takes priority over retire so back-to-back writes have no bubble.
      out_valid_d = 1'b1;
      out_rd_d    = mux_rd;
      out_wd_d    = mux_wd;
      sel_d       = pick_idx;
      last_d      = pick_idx;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_wd_q    <= '0;
      sel_q       <= SRC_ALU;
      last_q      <= SRC_AUX;
    end else begin
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_wd_q    <= out_wd_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
    end
  end

  // Writes to x0 retire silently.
  assign rf_we = retire & (out_rd_q != RW'(REG_X0));
  assign rf_rd = out_rd_q;
  assign rf_wd = out_wd_q;
  assign sel   = sel_q;
  assign busy  = out_valid_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0;
  logic [4:0]  r0 = '0, r1 = '0, r2 = '0;
  logic        rf_stall = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  sel;
  logic        busy;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (d0),
    .req_data1 (d1),
    .req_data2 (d2),
    .req_rd0   (r0),
    .req_rd1   (r1),
    .req_rd2   (r2),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the held entry plus a round-robin pointer.
  bit          m_valid = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;
  int          m_sel = 0;
  int          m_last = 2;
  logic [2:0]  m_acc = '0;

  function automatic int exp_idx();
    if (!rst_n) return -1;
    if (m_valid && rf_stall) return -1;
    for (int k = 1; k <= 3; k++) begin
      if (req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int g;
    g = exp_idx();
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  function automatic logic [31:0] dat(input int i);
    return (i == 0) ? d0 : (i == 1) ? d1 : d2;
  endfunction

  function automatic logic [4:0] rdx(input int i);
    return (i == 0) ? r0 : (i == 1) ? r1 : r2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rd    <= '0;
      m_wd    <= '0;
      m_sel   <= 0;
      m_last  <= 2;
      m_acc   <= '0;
    end else begin
      m_acc <= exp_ready();
      if (exp_idx() >= 0) begin
        m_valid <= 1'b1;
        m_wd    <= dat(exp_idx());
        m_rd    <= rdx(exp_idx());
        m_sel   <= exp_idx();
        m_last  <= exp_idx();
      end else if (m_valid && !rf_stall) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(req_ready), 32'(exp_ready()));
    chk("rf_we", 32'(rf_we), 32'(m_valid && !rf_stall && (m_rd != 5'd0)));
    chk("rf_rd", 32'(rf_rd), 32'(m_rd));
    chk("rf_wd", rf_wd, m_wd);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_valid));
  end

  task automatic drv(input logic [2:0] v, input logic st);
    @(posedge clk);
    #2;
    req_valid = v;
    rf_stall  = st;
  endtask

  initial begin : main
    bit found;
    int nfound;
    logic acc0;

    // Reset state, with requests present to show ready stays low.
    #3 req_valid = 3'b111;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 3'b000;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // All three valid: strict rotation starting at requester 0.
    r0 = 5'd1; r1 = 5'd2; r2 = 5'd3;
    drv(3'b111, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % 3)));
      if (c >= 1) begin
        chk("rr_we", 32'(rf_we), 32'd1);
        chk("rr_sel", 32'(sel), 32'((c - 1) % 3));
      end
    end
    drv(3'b000, 1'b0);
    @(negedge clk);
    chk("rr_last_sel", 32'(sel), 32'd2);
    chk("rr_last_we", 32'(rf_we), 32'd1);

    // Single load writeback.
    r1 = 5'd5; d1 = 32'hDEADBEEF;
    drv(3'b010, 1'b0);
    @(negedge clk);
    chk("ld_ready", 32'(req_ready), 32'b010);
    drv(3'b000, 1'b0);
    @(negedge clk);
    chk("ld_we", 32'(rf_we), 32'd1);
    chk("ld_rd", 32'(rf_rd), 32'd5);
    chk("ld_wd", rf_wd, 32'hDEADBEEF);
    chk("ld_sel", 32'(sel), 32'd1);

    // Entry held under stall while requester 0 waits.
    r0 = 5'd7; d0 = 32'hA5A50007;
    drv(3'b001, 1'b0);
    @(negedge clk);
    chk("st_first_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #2;
    r0 = 5'd8; d0 = 32'h0BAD0008; rf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_ready", 32'(req_ready), 32'd0);
      chk("st_we", 32'(rf_we), 32'd0);
      chk("st_rd", 32'(rf_rd), 32'd7);
      chk("st_wd", rf_wd, 32'hA5A50007);
      chk("st_busy", 32'(busy), 32'd1);
    end
    drv(3'b001, 1'b0);
    @(negedge clk);
    chk("st_rel_we", 32'(rf_we), 32'd1);
    chk("st_rel_rd", 32'(rf_rd), 32'd7);
    chk("st_rel_ready", 32'(req_ready), 32'b001);
    drv(3'b000, 1'b0);
    @(negedge clk);
    chk("st_next_rd", 32'(rf_rd), 32'd8);
    chk("st_next_wd", rf_wd, 32'h0BAD0008);

    // rd = 0 retires without a write; the following rd = 3 writes.
    r2 = 5'd0; d2 = 32'h12345678;
    drv(3'b100, 1'b0);
    @(negedge clk);
    chk("x0_ready", 32'(req_ready), 32'b100);
    @(posedge clk);
    #2;
    r2 = 5'd3; d2 = 32'hC0DE0003;
    @(negedge clk);
    chk("x0_busy", 32'(busy), 32'd1);
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_wd", rf_wd, 32'h12345678);
    chk("x0_refill_ready", 32'(req_ready), 32'b100);
    drv(3'b000, 1'b0);
    @(negedge clk);
    chk("x3_we", 32'(rf_we), 32'd1);
    chk("x3_rd", 32'(rf_rd), 32'd3);
    chk("x3_wd", rf_wd, 32'hC0DE0003);

    // Asynchronous reset while an entry is stalled.
    r0 = 5'd9; d0 = 32'h99990009;
    drv(3'b001, 1'b0);
    @(posedge clk);
    #2;
    req_valid = 3'b000;
    rf_stall = 1'b1;
    @(negedge clk);
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_we", 32'(rf_we), 32'd0);
    chk("ar_rd", 32'(rf_rd), 32'd0);
    req_valid = 3'b111;
    #1;
    chk("ar_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rf_stall = 1'b0;
    @(negedge clk);
    chk("ar_first_grant", 32'(req_ready), 32'b001);
    drv(3'b000, 1'b0);

    // Fairness: pointer parked on 2, then 2 competes with a toggling 0.
    drv(3'b100, 1'b0);
    drv(3'b101, 1'b0);
    found = 1'b0;
    nfound = 0;
    for (int k = 1; k <= 3; k++) begin
      if (!found) begin
        @(negedge clk);
        if (req_ready[2]) begin
          found = 1'b1;
          nfound = k;
        end else begin
          acc0 = req_ready[0];
          @(posedge clk);
          #2;
          req_valid[0] = acc0 ? 1'b0 : 1'b1;
        end
      end
    end
    chk("starve_bound", 32'(found), 32'd1);
    chk("starve_cycles", 32'(nfound), 32'd2);
    drv(3'b000, 1'b0);

    // Randomized traffic; requesters hold until the model sees acceptance.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          req_valid[i] = ($urandom % 3) != 0;
          case (i)
            0: begin d0 = $urandom; r0 = 5'($urandom % 32); end
            1: begin d1 = $urandom; r1 = 5'($urandom % 32); end
            default: begin d2 = $urandom; r2 = 5'($urandom % 32); end
          endcase
        end
      end
      rf_stall = ($urandom % 4) == 0;
      if (($urandom % 400) == 0) begin
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
